// File: rtl/iir_out_pkg.sv
// Shared defaults and fixed-point constants for the IIR output buffer.
package iir_out_pkg;

  localparam int unsigned W_DEF     = 14;
  localparam int unsigned OW_DEF    = 11;
  localparam int unsigned DEPTH_DEF = 8;

  // Headroom bits so a gain of up to 2^3 never wraps before rounding.
  localparam int unsigned GUARD = 3;

  // Half an output LSB, added before truncation to round to nearest.
  function automatic int rnd_const(input int w, input int ow);
    return 1 << (w - ow - 1);
  endfunction

  // Largest representable output sample.
  function automatic int sat_max(input int ow);
    return (1 << ow) - 1;
  endfunction

  // Smallest representable output sample.
  function automatic int sat_min(input int ow);
    return -(1 << ow);
  endfunction

  localparam int RND_DEF     = rnd_const(int'(W_DEF), int'(OW_DEF));
  localparam int SAT_MAX_DEF = sat_max(int'(OW_DEF));
  localparam int SAT_MIN_DEF = sat_min(int'(OW_DEF));

endpackage

// File: rtl/iir_out_buf_fifo.sv
// Synchronous first-in first-out buffer with drop-on-full and no write-to-read bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_drop_c,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_c, rd_c, wr_c;

  // Pointer/occupancy bookkeeping; a read frees the slot a full-time write needs.
  always_comb begin
    full_c    = (count_q == LW'(DEPTH));
    rd_c      = valid_q && rd_ready;
    wr_c      = wr_en && (!full_c || rd_c);
    wr_drop_c = wr_en && full_c && !rd_c;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_c, rd_c})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != LW'(0));
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = valid_q;
  assign level    = count_q;

endmodule

// File: rtl/iir_out_buf.sv
// IIR output stage: optional decimation, gain, round, saturate, then buffer.
module iir_out_buf
  import iir_out_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned OW    = OW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W:0]             y_in,
  input  logic                   in_en,
  input  logic                   dec_en,
  input  logic                   phase_sel,
  input  logic [1:0]             shift,
  input  logic                   clr_ovf,
  output logic [OW:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [7:0]             sat_cnt
);

  localparam int unsigned XW = W + 1 + GUARD;
  localparam int unsigned DW = OW + 1;
  localparam int unsigned SH = W - OW;

  localparam logic signed [XW-1:0] RND    = XW'(rnd_const(int'(W), int'(OW)));
  localparam logic signed [XW-1:0] SAT_HI = XW'(sat_max(int'(OW)));
  localparam logic signed [XW-1:0] SAT_LO = XW'(sat_min(int'(OW)));

  logic                 phase_q, phase_d;
  logic                 accept_c;
  logic signed [XW-1:0] s1_q, s1_d;
  logic                 s1_vld_q, s1_vld_d;
  logic signed [XW-1:0] r_c;
  logic [DW-1:0]        s2_data_q, s2_data_d;
  logic                 s2_sat_q, s2_sat_d;
  logic                 s2_vld_q, s2_vld_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           sat_cnt_q, sat_cnt_d;
  logic                 fifo_drop_c;

  // Stage 1: phase tracking, decimation gate, gain and rounding offset.
  always_comb begin
    phase_d  = phase_q ^ in_en;
    accept_c = in_en && (!dec_en || (phase_q == phase_sel));
    s1_vld_d = accept_c;
    s1_d     = s1_q;
    if (accept_c) s1_d = ($signed({{GUARD{y_in[W]}}, y_in}) <<< shift) + RND;
  end

  // Stage 2: drop the fraction and clamp into the output range.
  always_comb begin
    r_c       = s1_q >>> SH;
    s2_vld_d  = s1_vld_q;
    s2_data_d = s2_data_q;
    s2_sat_d  = s2_sat_q;
    if (s1_vld_q) begin
      if (r_c > SAT_HI) begin
        s2_data_d = SAT_HI[DW-1:0];
        s2_sat_d  = 1'b1;
      end else if (r_c < SAT_LO) begin
        s2_data_d = SAT_LO[DW-1:0];
        s2_sat_d  = 1'b1;
      end else begin
        s2_data_d = r_c[DW-1:0];
        s2_sat_d  = 1'b0;
      end
    end
  end

  // Sticky status; a set/increment in the same cycle as a clear takes priority.
  always_comb begin
    ovf_d     = ovf_q;
    sat_cnt_d = sat_cnt_q;
    if (clr_ovf) begin
      ovf_d     = 1'b0;
      sat_cnt_d = 8'd0;
    end
    if (fifo_drop_c) ovf_d = 1'b1;
    if (s2_vld_q && s2_sat_q) begin
      if (clr_ovf)                sat_cnt_d = 8'd1;
      else if (sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
    end
  end

  // Pipeline and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= 1'b0;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      sat_cnt_q <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      s2_data_q <= s2_data_d;
      s2_sat_q  <= s2_sat_d;
      s2_vld_q  <= s2_vld_d;
      ovf_q     <= ovf_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (s2_vld_q),
    .wr_data   (s2_data_q),
    .wr_drop_c (fifo_drop_c),
    .rd_data   (m_data),
    .rd_valid  (m_valid),
    .rd_ready  (m_ready),
    .level     (level)
  );

  assign ovf     = ovf_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_iir_out_buf.sv
// Scoreboard bench for iir_out_buf at default parameters.
module tb_iir_out_buf;

  localparam int W     = 14;
  localparam int OW    = 11;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W:0]    y_in;
  logic          in_en, dec_en, phase_sel, clr_ovf, m_ready;
  logic [1:0]    shift;
  logic [OW:0]   m_data;
  logic          m_valid;
  logic [3:0]    level;
  logic          ovf;
  logic [7:0]    sat_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;
  bit            tb_phase = 1'b0;
  logic [OW:0]   sb_q[$];
  logic [OW:0]   exp_v;

  always #5 clk = ~clk;

  iir_out_buf #(.W(W), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .in_en     (in_en),
    .dec_en    (dec_en),
    .phase_sel (phase_sel),
    .shift     (shift),
    .clr_ovf   (clr_ovf),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .ovf       (ovf),
    .sat_cnt   (sat_cnt)
  );

  // Reference: gain, round half up, floor shift, clamp.
  function automatic logic [OW:0] model(input int y, input int sh);
    int r;
    r = ((y * (1 << sh)) + (1 << (W - OW - 1))) >>> (W - OW);
    if (r > (1 << OW) - 1) r = (1 << OW) - 1;
    else if (r < -(1 << OW)) r = -(1 << OW);
    return (OW+1)'(r);
  endfunction

  // Scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      n_checks++;
      n_pops++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got m_data=%0d, required no output", $signed(m_data));
      end else begin
        exp_v = sb_q.pop_front();
        if (m_data !== exp_v) begin
          n_fail++;
          $display("FAIL scoreboard_data: got %0d, required %0d", $signed(m_data), $signed(exp_v));
        end
      end
    end
  end

  task automatic send(input int y, input bit push);
    @(posedge clk); #1;
    y_in  = 15'(y);
    in_en = 1'b1;
    if (push && (!dec_en || (tb_phase == phase_sel))) sb_q.push_back(model(y, int'(shift)));
    tb_phase = ~tb_phase;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_en = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    in_en = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tb_phase = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    n_checks++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d, required 0", sat_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic mv [4];
    int   pops0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    pops0 = n_pops;
    send(4, 1);   @(negedge clk); mv[0] = m_valid;
    send(-12, 1); @(negedge clk); mv[1] = m_valid;
    send(-2, 1);  @(negedge clk); mv[2] = m_valid;
    @(posedge clk); #1; in_en = 1'b0;
    @(negedge clk); mv[3] = m_valid;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mv[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_latency cycle+%0d: got m_valid=%b, required %b", k, mv[k], (k == 3));
      end
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    @(negedge clk);
    n_checks++; if (n_pops - pops0 !== 3) begin n_fail++; $display("FAIL basic_count: got %0d outputs, required 3", n_pops - pops0); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL basic_level: got %0d, required 0", level); end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    shift = 2'd1;
    send(16383, 1);
    idle(4);
    @(negedge clk);
    n_checks++; if (sat_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_cnt_pos: got %0d, required 1", sat_cnt); end
    send(-16384, 1);
    idle(4);
    @(negedge clk);
    n_checks++; if (sat_cnt !== 8'd2) begin n_fail++; $display("FAIL sat_cnt_neg: got %0d, required 2", sat_cnt); end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sat_drain: got %0d pending, required 0", sb_q.size()); end
    @(posedge clk); #1;
    shift = 2'd0;
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8 * (i + 1), i < 8);
    idle(4);
    @(negedge clk);
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level_full: got %0d, required 8", level); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", ovf); end
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_m_valid: got %b, required 1", m_valid); end
    idle(2);
    @(negedge clk);
    n_checks++; if (m_data !== sb_q[0]) begin n_fail++; $display("FAIL ovf_hold_head: got %0d, required %0d", $signed(m_data), $signed(sb_q[0])); end
    send(200, 1);
    @(posedge clk); #1; in_en = 1'b0;
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_rw_full_level: got %0d, required 8", level); end
    @(posedge clk); #1; m_ready = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    @(negedge clk);
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL ovf_drain: got %0d pending, required 0", sb_q.size()); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL ovf_level_empty: got %0d, required 0", level); end
  endtask

  task automatic test_clr_ovf();
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_alone: got %b, required 0", ovf); end
    n_checks++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_sat_alone: got %0d, required 0", sat_cnt); end
    @(posedge clk); #1;
    shift = 2'd3;
    for (int i = 0; i < 7; i++) send(8 * i, 1);
    send(16383, 1);
    send(-16384, 0);
    @(posedge clk); #1; in_en = 1'b0;
    @(posedge clk); #1; clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    @(negedge clk);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_ovf_event: got %b, required 1", ovf); end
    n_checks++; if (sat_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_vs_sat_event: got %0d, required 1", sat_cnt); end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL clr_level: got %0d, required 8", level); end
    @(posedge clk); #1;
    m_ready = 1'b1;
    shift   = 2'd0;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    @(negedge clk);
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL clr_drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_decimate();
    int pops0;
    pulse_reset();
    dec_en    = 1'b1;
    phase_sel = 1'b1;
    m_ready   = 1'b1;
    pops0     = n_pops;
    send(8, 1);
    send(16, 1);
    send(24, 1);
    send(32, 1);
    idle(6);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    @(negedge clk);
    n_checks++; if (n_pops - pops0 !== 2) begin n_fail++; $display("FAIL decim_count: got %0d outputs, required 2", n_pops - pops0); end
    n_checks++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL decim_sat_cnt: got %0d, required 0", sat_cnt); end
    @(posedge clk); #1;
    dec_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic mv [4];
    @(posedge clk); #1;
    m_ready = 1'b0;
    dec_en  = 1'b0;
    for (int i = 0; i < 5; i++) send(8 * (i + 1), 0);
    @(posedge clk); #1;
    in_en = 1'b0;
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL midrst_pre_level: got %0d, required 3", level); end
    reset = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b, required 0", m_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL midrst_level: got %0d, required 0", level); end
    #1;
    reset     = 1'b0;
    tb_phase  = 1'b0;
    sb_q.delete();
    dec_en    = 1'b1;
    phase_sel = 1'b0;
    m_ready   = 1'b1;
    send(40, 1);
    @(negedge clk); mv[0] = m_valid;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1; in_en = 1'b0;
      @(negedge clk); mv[k] = m_valid;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mv[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL midrst_latency cycle+%0d: got m_valid=%b, required %b", k, mv[k], (k == 3));
      end
    end
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    idle(3);
    @(negedge clk);
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL midrst_drain: got %0d pending, required 0", sb_q.size()); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_empty: got m_valid=%b, required 0", m_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    y_in      = '0;
    in_en     = 1'b0;
    dec_en    = 1'b0;
    phase_sel = 1'b0;
    shift     = 2'd0;
    clr_ovf   = 1'b0;
    m_ready   = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_clr_ovf();
    test_decimate();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_out_buf.md
IIR_OUT_BUF -- requirements
Module: iir_out_buf

Interface
REQ-001 Parameter W, default 14: input sample is W+1 bits, two's complement.
REQ-002 Parameter OW, default 11: output sample is OW+1 bits, two's complement; OW < W.
REQ-003 Parameter DEPTH, default 8: FIFO entries; power of two, at least 2.
REQ-004 Port clk, input, 1 bit: single clock, rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port y_in, input, W+1 bits: filter output sample from the parallel IIR stage, one per clk.
REQ-007 Port in_en, input, 1 bit: y_in is valid this cycle.
REQ-008 Port dec_en, input, 1 bit: 1 keeps one sample of every two (decimate by 2); 0 keeps all samples.
REQ-009 Port phase_sel, input, 1 bit: selects which phase is kept when dec_en=1.
REQ-010 Port shift, input, 2 bits: gain of 2^shift (0..3), applied before rounding.
REQ-011 Port clr_ovf, input, 1 bit: synchronous clear of ovf and sat_cnt.
REQ-012 Port m_data, output, OW+1 bits: FIFO head sample.
REQ-013 Port m_valid, output, 1 bit: m_data is valid.
REQ-014 Port m_ready, input, 1 bit: consumer accepts m_data.
REQ-015 Port level, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-016 Port ovf, output, 1 bit: sticky flag, set when a sample is dropped because the FIFO is full.
REQ-017 Port sat_cnt, output, 8 bits: count of saturated samples; holds at 255.

Function
REQ-018 A 1-bit phase counter toggles on every in_en=1 cycle, whatever the value of dec_en.
REQ-019 A sample is accepted when in_en=1 and either dec_en=0 or the phase counter equals phase_sel before the toggle.
REQ-020 Stage 1 (registered): s1 = (y_in sign-extended by 3 bits, shifted left by shift) + 2^(W-OW-1).
REQ-021 Stage 2 (registered): r = s1 arithmetic-shifted right by W-OW, then saturated to the range [-2^OW, 2^OW-1].
REQ-022 Stage 2 also flags the sample as saturated when r was clamped.
REQ-023 Every accepted sample that reaches stage 2 and was clamped increments sat_cnt, which holds at 255.
REQ-024 Stage 2 output writes into the FIFO at the end of its cycle; a sample accepted in cycle N makes m_valid=1 in cycle N+3 when the FIFO was empty.
REQ-025 A read occurs when m_valid=1 and m_ready=1; the FIFO is first-in first-out.
REQ-026 While m_valid=1 and m_ready=0, m_data and m_valid shall hold stable.
REQ-027 When the FIFO is full and no read occurs, the write is dropped and ovf is set to 1.
REQ-028 When the FIFO is full and a read occurs in the same cycle, the write is accepted and level is unchanged.
REQ-029 When the FIFO is empty, m_valid=0 and m_data is don't-care; there is no write-to-read bypass.
REQ-030 clr_ovf=1 clears ovf and sat_cnt; if a set or increment event occurs in the same cycle, the event wins (ovf=1, sat_cnt=1).
REQ-031 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-032 level ranges from 0 to DEPTH inclusive.
REQ-033 A change of shift, dec_en or phase_sel takes effect from the next in_en cycle; samples already in the pipeline are not altered.

Reset
REQ-034 reset=1 asynchronously clears the phase counter, pipeline valid bits, pointers, level, ovf and sat_cnt, and drives m_valid=0.
REQ-035 Reset asserted mid-stream discards all pipeline and FIFO contents; after release, the first accepted sample uses phase 0.
REQ-036 FIFO storage RAM contents are not reset.

Structure
REQ-037 Package iir_out_pkg holds the W, OW and DEPTH defaults, the rounding constant and the saturation limits.
REQ-038 The FIFO is a sub-module, sync_fifo (parameters: width, depth), instantiated once; rounding and saturation logic stays in iir_out_buf.

Verification
REQ-039 shift=0, dec_en=0, inputs 4, -12, -2 -> m_data 1, -1, 0, with the first m_valid three cycles after the first in_en.
REQ-040 shift=1, y_in=16383 -> m_data 2047, sat_cnt=1; y_in=-16384 -> m_data -2048, sat_cnt=2.
REQ-041 dec_en=1, phase_sel=1, inputs 8, 16, 24, 32 (shift=0) -> m_data 2, 4 only.
REQ-042 m_ready=0, 10 samples at DEPTH=8 -> level=8, ovf=1, first 8 samples preserved in order; m_ready=1 with a simultaneous write while full -> level stays 8.
REQ-043 clr_ovf=1 in the same cycle as an overflow -> ovf remains 1; clr_ovf=1 alone -> ovf=0, sat_cnt=0.
REQ-044 reset pulse with 5 samples in flight -> m_valid=0 and level=0 immediately; the next sample appears after 3 cycles.
